// File: rtl/sar_search.sv
// sar_search - successive-approximation search engine.
//
// Drives a trial word 'guess' to an external magnitude comparator
// (a = target, b = guess) and reads back cmp_ge = (target >= guess).
// Resolves the target one bit per trial, MSB first.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    begin a search (sampled only when idle)
//   cmp_ge   comparator answer for the current guess
//   guess    trial word presented to the comparator b input
//   busy     high from the cycle after start up to and including the done cycle
//   done     one-cycle pulse; result valid from this cycle
//   result   final resolved value, held until the next done
//
// Build option:
//   SAR_SETTLE_EN  insert one SETTLE cycle before every trial so that a
//                  comparator with one registered stage can be used.
//                  cmp_ge is ignored during SETTLE.

module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cmp_ge,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SAR_SETTLE_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIAL,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_DONE
    } state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] guess_n;
    logic [WIDTH-1:0] result_n;
    logic [IW-1:0]    idx, idx_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            guess  <= '0;
            result <= '0;
            idx    <= IW'(WIDTH - 1);
        end else begin
            state  <= state_n;
            guess  <= guess_n;
            result <= result_n;
            idx    <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        guess_n  = guess;
        result_n = result;
        idx_n    = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    guess_n            = '0;
                    guess_n[WIDTH-1]   = 1'b1;
                    idx_n              = IW'(WIDTH - 1);
`ifdef SAR_SETTLE_EN
                    state_n            = S_SETTLE;
`else
                    state_n            = S_TRIAL;
`endif
                end
            end
`ifdef SAR_SETTLE_EN
            S_SETTLE: begin
                state_n = S_TRIAL;
            end
`endif
            S_TRIAL: begin
                // Keep the trial bit only if the target is at least the guess.
                guess_n[idx] = cmp_ge;
                if (idx == '0) begin
                    // guess_n already carries the resolved LSB here.
                    result_n = guess_n;
                    state_n  = S_DONE;
                end else begin
                    guess_n[idx - IW'(1)] = 1'b1;
                    idx_n                 = idx - IW'(1);
`ifdef SAR_SETTLE_EN
                    state_n               = S_SETTLE;
`else
                    state_n               = S_TRIAL;
`endif
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
